// File: rtl/cpr_lane_src.sv
// cpr_lane_src: per-lane record source for the s-minimum comparator tree.
// Buffers an ordered {FDSSI, SSI, s, FDSTI} stream in a small FIFO, presents
// the head with the tree's valid/wt lane encoding, and flags order violations.
module cpr_lane_src #(
  parameter int FDSSI_WIDTH = 12,
  parameter int SSI_WIDTH   = 8,
  parameter int S_WIDTH     = 2,
  parameter int FDSTI_WIDTH = 28,
  parameter int DEPTH       = 4,
  parameter int AW          = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_last,
  input  logic [FDSSI_WIDTH-1:0] in_fdssi,
  input  logic [SSI_WIDTH-1:0]   in_ssi,
  input  logic [S_WIDTH-1:0]     in_s,
  input  logic [FDSTI_WIDTH-1:0] in_fdsti,
  input  logic                   restart,
  input  logic                   pop,
  output logic                   valid,
  output logic                   wt,
  output logic [FDSSI_WIDTH-1:0] FDSSI,
  output logic [SSI_WIDTH-1:0]   SSI,
  output logic [S_WIDTH-1:0]     s,
  output logic [FDSTI_WIDTH-1:0] FDSTI,
  output logic [AW:0]            count,
  output logic                   ord_err
);

  localparam int ABS_W = FDSSI_WIDTH + S_WIDTH + 1;
  localparam int REC_W = FDSSI_WIDTH + SSI_WIDTH + S_WIDTH + FDSTI_WIDTH;
  localparam logic [AW:0]   FULL_C  = (AW+1)'(DEPTH);
  localparam logic [AW:0]   ONE_C   = (AW+1)'(1);
  localparam logic [AW:0]   ZERO_C  = (AW+1)'(0);
  localparam logic [AW-1:0] PSTEP_C = AW'(1);

  typedef enum logic [1:0] {
    ST_WAIT = 2'd0,
    ST_LAST = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Absolute s coordinate used for the non-decreasing order check.
  function automatic logic [ABS_W-1:0] abs_of(
    input logic [FDSSI_WIDTH-1:0] f,
    input logic [SSI_WIDTH-1:0]   ss,
    input logic [S_WIDTH-1:0]     sv
  );
    abs_of = (ABS_W'(f) << S_WIDTH) + ABS_W'(ss) + ABS_W'(sv);
  endfunction

  logic [REC_W-1:0] mem [DEPTH];
  logic [REC_W-1:0] head;
  logic [REC_W-1:0] head_nxt;
  logic [REC_W-1:0] rec_in;
  logic [AW-1:0]    wr_ptr, rd_ptr, wr_nxt, rd_nxt;
  logic [AW:0]      cnt_nxt;
  logic [ABS_W-1:0] abs_in, last_abs;
  logic             last_abs_vld;
  logic             push, do_pop, restart_ok;
  state_t           state, state_nxt;

  assign rec_in = {in_fdssi, in_ssi, in_s, in_fdsti};
  assign abs_in = abs_of(in_fdssi, in_ssi, in_s);
  assign {FDSSI, SSI, s, FDSTI} = head;

  // Next-state decode for pointers, occupancy, FSM and the registered head.
  always_comb begin
    push       = in_valid & in_ready;
    do_pop     = pop & valid;
    restart_ok = restart & (state == ST_DONE);
    wr_nxt     = push   ? wr_ptr + PSTEP_C : wr_ptr;
    rd_nxt     = do_pop ? rd_ptr + PSTEP_C : rd_ptr;
    case ({push, do_pop})
      2'b10:   cnt_nxt = count + ONE_C;
      2'b01:   cnt_nxt = count - ONE_C;
      default: cnt_nxt = count;
    endcase
    case (state)
      ST_WAIT: begin
        if (push && in_last) state_nxt = ST_LAST;
        else                 state_nxt = ST_WAIT;
      end
      ST_LAST: begin
        if (cnt_nxt == ZERO_C) state_nxt = ST_DONE;
        else                   state_nxt = ST_LAST;
      end
      ST_DONE: begin
        if (restart_ok) state_nxt = ST_WAIT;
        else            state_nxt = ST_DONE;
      end
      default: state_nxt = ST_WAIT;
    endcase
    // The storage array is never reset, so an empty lane shows zeros; a
    // record pushed this cycle that becomes head is taken from the input.
    if (cnt_nxt == ZERO_C)               head_nxt = '0;
    else if (push && (wr_ptr == rd_nxt)) head_nxt = rec_in;
    else                                 head_nxt = mem[rd_nxt];
  end

  // FIFO storage write; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (!rst && push) mem[wr_ptr] <= rec_in;
  end

  // Control state, registered lane outputs and the sticky order check.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= ZERO_C;
      state        <= ST_WAIT;
      head         <= '0;
      valid        <= 1'b0;
      wt           <= 1'b1;
      in_ready     <= 1'b1;
      ord_err      <= 1'b0;
      last_abs     <= '0;
      last_abs_vld <= 1'b0;
    end else begin
      wr_ptr   <= wr_nxt;
      rd_ptr   <= rd_nxt;
      count    <= cnt_nxt;
      state    <= state_nxt;
      head     <= head_nxt;
      valid    <= (cnt_nxt != ZERO_C);
      wt       <= (cnt_nxt == ZERO_C) && (state_nxt != ST_DONE);
      in_ready <= (state_nxt == ST_WAIT) && (cnt_nxt < FULL_C);
      if (restart_ok) begin
        ord_err      <= 1'b0;
        last_abs_vld <= 1'b0;
      end else if (push) begin
        if (last_abs_vld && (abs_in < last_abs)) ord_err <= 1'b1;
        last_abs     <= abs_in;
        last_abs_vld <= 1'b1;
      end
    end
  end

endmodule
